// File: rtl/instr_feeder_pkg.sv
// Shared SoftMC opcode constants and feeder FSM types.
// The opcode field lives in [31:28] of every instruction word.
package instr_feeder_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 28;

    localparam logic [3:0] OP_END_ISEQ  = 4'b0000;
    localparam logic [3:0] OP_WAIT      = 4'b0010;
    localparam logic [3:0] OP_DDR_INSTR = 4'b0100;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } feed_state_t;

    function automatic logic is_end(input logic [31:0] word);
        return word[OP_HI:OP_LO] == OP_END_ISEQ;
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Host stream + two-slot dispatcher handshake seen by instr_feeder.
// The feeder is the slave; the host/dispatcher side is the master.
interface instr_feeder_if #(parameter int AW = 10);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            en_in0;
    logic            en_ack0;
    logic [31:0]     instr_in0;
    logic            en_in1;
    logic            en_ack1;
    logic [31:0]     instr_in1;
    logic            busy;
    logic [AW+1:0]   prog_len;

    modport master (
        output in_valid, in_instr, en_ack0, en_ack1,
        input  in_ready, en_in0, instr_in0, en_in1, instr_in1, busy, prog_len
    );

    modport slave (
        input  in_valid, in_instr, en_ack0, en_ack1,
        output in_ready, en_in0, instr_in0, en_in1, instr_in1, busy, prog_len
    );

endinterface

// File: rtl/instr_fifo.sv
// Single-clock first-word-fall-through queue, DEPTH x 32.
// Wrap-bit pointers give exact full/empty; a write shows at dout one cycle later.
module instr_fifo #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] din,
    output logic        full,
    input  logic        rd_en,
    output logic [31:0] dout,
    output logic        empty
);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        wr_ok, rd_ok;

    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr[AW-1:0]] <= din;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/instr_feeder.sv
// Steers host instructions alternately into two slot queues and withholds
// the queue heads from the dispatcher until a whole program is buffered.
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic           clk,
    input  logic           rst,
    instr_feeder_if.slave  bus
);

    localparam logic [AW+1:0] LEN_MAX = (AW+2)'(2 * DEPTH);

    feed_state_t          state, state_n;
    logic                 wr_sel, tgt, accept, in_ready, drain_done;
    logic [1:0]           full, empty, push, pop, en, ack;
    logic [1:0][31:0]     dout;
    logic [AW+1:0]        prog_len;

    // With both queues empty the dispatcher reselects slot 0, so writes must too.
    assign tgt        = (&empty) ? 1'b0 : wr_sel;
    assign in_ready   = ~rst & (state == FILL) & ~full[tgt];
    assign accept     = bus.in_valid & in_ready;
    assign drain_done = &empty;
    assign ack        = {bus.en_ack1, bus.en_ack0};

    generate
        for (genvar k = 0; k < 2; k++) begin : g_slot
            assign push[k] = accept & (tgt == 1'(k));
            assign en[k]   = ~rst & (state == DRAIN) & ~empty[k];
            assign pop[k]  = en[k] & ack[k];

            instr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .wr_en (push[k]),
                .din   (bus.in_instr),
                .full  (full[k]),
                .rd_en (pop[k]),
                .dout  (dout[k]),
                .empty (empty[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_n;
    end

    // Release on the terminator, or early when the next target queue is
    // already full so a program longer than the buffer cannot deadlock.
    always_comb begin
        state_n = state;
        case (state)
            FILL:    if (accept && (is_end(bus.in_instr) || full[~tgt])) state_n = DRAIN;
            DRAIN:   if (drain_done) state_n = FILL;
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel   <= 1'b0;
            prog_len <= '0;
        end else if (state == DRAIN && drain_done) begin
            wr_sel   <= 1'b0;
            prog_len <= '0;
        end else if (accept) begin
            wr_sel <= ~tgt;
            if (prog_len != LEN_MAX) prog_len <= prog_len + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.en_in0    = en[0];
    assign bus.en_in1    = en[1];
    assign bus.instr_in0 = en[0] ? dout[0] : '0;
    assign bus.instr_in1 = en[1] ? dout[1] : '0;
    assign bus.busy      = ~rst & (state == DRAIN) & ~drain_done;
    assign bus.prog_len  = prog_len;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder with DEPTH=4 so overflow release is reachable.
module tb_instr_feeder;
    import instr_feeder_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_feeder_if #(.AW(AW)) bus();

    instr_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] w(input logic [3:0] op, input logic [27:0] arg);
        return {op, arg};
    endfunction

    task automatic send(input logic [31:0] d);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = d;
        while (!bus.in_ready && t < 40) begin
            step();
            t++;
        end
        if (t == 40) chk("send_timeout", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic acks(input logic a0, input logic a1);
        bus.en_ack0 = a0;
        bus.en_ack1 = a1;
    endtask

    task automatic heads(input string tag, input logic [31:0] h0, input logic [31:0] h1);
        chk({tag, "_en0"},   32'(bus.en_in0), 32'd1);
        chk({tag, "_head0"}, bus.instr_in0, h0);
        chk({tag, "_en1"},   32'(bus.en_in1), 32'd1);
        chk({tag, "_head1"}, bus.instr_in1, h1);
    endtask

    // Acks both slots until busy drops, then steps into FILL.
    task automatic drain_all(input string tag);
        int t;
        t = 0;
        acks(1'b1, 1'b1);
        while (bus.busy && t < 40) begin
            step();
            t++;
        end
        chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        acks(1'b0, 1'b0);
        step();
        chk({tag, "_ready"},   32'(bus.in_ready), 32'd1);
        chk({tag, "_len_clr"}, 32'(bus.prog_len), 32'd0);
    endtask

    logic [31:0] wa, wb, wc, wd, we, wend, wx, wy;
    logic [31:0] wv [9];

    initial begin
        wa   = w(OP_DDR_INSTR, 28'h00000A1);
        wb   = w(OP_DDR_INSTR, 28'h00000B2);
        wc   = w(OP_DDR_INSTR, 28'h00000C3);
        wd   = w(OP_WAIT,      28'h0000010);
        we   = w(OP_DDR_INSTR, 28'h00000E5);
        wend = w(OP_END_ISEQ,  28'h0000E0D);
        wx   = w(OP_DDR_INSTR, 28'h0000F01);
        wy   = w(OP_DDR_INSTR, 28'h0000F02);
        for (int i = 0; i < 9; i++) wv[i] = w(OP_DDR_INSTR, 28'(32'h100 + i));

        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        acks(1'b0, 1'b0);

        // reset
        #1;
        chk("rst_ready_comb", 32'(bus.in_ready), 32'd0);
        step();
        chk("rst_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_en0",    32'(bus.en_in0),    32'd0);
        chk("rst_en1",    32'(bus.en_in1),    32'd0);
        chk("rst_instr0", bus.instr_in0,      32'd0);
        chk("rst_instr1", bus.instr_in1,      32'd0);
        chk("rst_busy",   32'(bus.busy),      32'd0);
        chk("rst_len",    32'(bus.prog_len),  32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // 1: A B C END, heads gated during fill
        send(wa);
        chk("t1_gate0", 32'(bus.en_in0), 32'd0);
        send(wb);
        chk("t1_gate1", 32'(bus.en_in1), 32'd0);
        send(wc);
        chk("t1_len3", 32'(bus.prog_len), 32'd3);
        send(wend);
        heads("t1_first", wa, wb);
        chk("t1_busy",   32'(bus.busy),     32'd1);
        chk("t1_len4",   32'(bus.prog_len), 32'd4);
        chk("t1_nordy",  32'(bus.in_ready), 32'd0);
        acks(1'b1, 1'b1);
        step();
        heads("t1_second", wc, wend);
        step();
        acks(1'b0, 1'b0);
        chk("t1_busy_drop", 32'(bus.busy),   32'd0);
        chk("t1_en0_off",   32'(bus.en_in0), 32'd0);
        step();
        chk("t1_len_clr", 32'(bus.prog_len), 32'd0);
        chk("t1_ready",   32'(bus.in_ready), 32'd1);

        // 2: odd program then new program restarts at slot 0
        send(wa);
        send(wend);
        heads("t2_odd", wa, wend);
        drain_all("t2_odd");
        send(wx);
        send(wy);
        send(wend);
        heads("t2_new", wx, wy);
        acks(1'b1, 1'b1);
        step();
        acks(1'b0, 1'b0);
        chk("t2_end_slot0", bus.instr_in0, wend);
        chk("t2_slot1_empty", 32'(bus.en_in1), 32'd0);
        drain_all("t2_new");

        // 4: ack without en during fill is ignored
        acks(1'b1, 1'b1);
        send(wa);
        send(wb);
        chk("t4_en0", 32'(bus.en_in0), 32'd0);
        chk("t4_len", 32'(bus.prog_len), 32'd2);
        acks(1'b0, 1'b0);
        send(wend);
        heads("t4_heads", wa, wb);
        chk("t4_len3", 32'(bus.prog_len), 32'd3);
        drain_all("t4");

        // 5: slot 1 blocked, slot 0 drains alone
        send(wa); send(wb); send(wc); send(wd); send(we); send(wend);
        heads("t5_start", wa, wb);
        acks(1'b1, 1'b0);
        step();
        heads("t5_p1", wc, wb);
        step();
        heads("t5_p2", we, wb);
        step();
        acks(1'b0, 1'b0);
        chk("t5_en0_off", 32'(bus.en_in0), 32'd0);
        chk("t5_head1",   bus.instr_in1,   wb);
        chk("t5_busy",    32'(bus.busy),   32'd1);
        acks(1'b0, 1'b1);
        step();
        chk("t5_s1_next", bus.instr_in1, wd);
        acks(1'b0, 1'b0);
        drain_all("t5");

        // 3: overflow release after 8 words, word 9 held until drained
        for (int i = 0; i < 8; i++) send(wv[i]);
        chk("t3_busy",  32'(bus.busy),     32'd1);
        chk("t3_len8",  32'(bus.prog_len), 32'd8);
        chk("t3_nordy", 32'(bus.in_ready), 32'd0);
        heads("t3_first", wv[0], wv[1]);
        bus.in_valid = 1'b1;
        bus.in_instr = wv[8];
        step();
        chk("t3_held_rdy", 32'(bus.in_ready), 32'd0);
        chk("t3_held_len", 32'(bus.prog_len), 32'd8);
        acks(1'b1, 1'b1);
        step();
        acks(1'b0, 1'b0);
        heads("t3_second", wv[2], wv[3]);
        drain_all("t3");
        step();
        bus.in_valid = 1'b0;
        chk("t3_w9_len", 32'(bus.prog_len), 32'd1);
        send(wend);
        heads("t3_w9", wv[8], wend);
        drain_all("t3_w9");

        // 6: reset mid-drain
        send(wa); send(wb); send(wend);
        chk("t6_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_en0",  32'(bus.en_in0),   32'd0);
        chk("t6_en1",  32'(bus.en_in1),   32'd0);
        chk("t6_busy", 32'(bus.busy),     32'd0);
        chk("t6_len",  32'(bus.prog_len), 32'd0);
        step();
        chk("t6_ready", 32'(bus.in_ready), 32'd1);
        send(wx);
        send(wend);
        heads("t6_after", wx, wend);
        drain_all("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
